// File: rtl/qc_rce_encoder_par.sv
// rtl/qc_rce_encoder_par.sv - P-bit-parallel systematic quasi-cyclic encoder with rotating circulant generators
// Streams KB*B message bits in, fetches per-block generator rows from a synchronous ROM, emits message then NP*B parity bits.
module qc_rce_encoder_par #(
  parameter int B  = 32,
  parameter int KB = 4,
  parameter int NP = 2,
  parameter int P  = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  sys_en,
  input  logic [P-1:0]                          s_data,
  input  logic                                  s_valid,
  output logic                                  s_ready,
  output logic [((KB > 1) ? $clog2(KB) : 1)-1:0] g_addr,
  input  logic [NP*B-1:0]                       g_data,
  output logic [P-1:0]                          m_data,
  output logic                                  m_valid,
  input  logic                                  m_ready,
  output logic                                  m_par,
  output logic                                  m_last,
  output logic                                  busy
);

  localparam int GW  = NP * B;
  localparam int WPB = B / P;
  localparam int NQ  = GW / P;
  localparam int AW  = (KB > 1) ? $clog2(KB) : 1;
  localparam int WW  = (WPB > 1) ? $clog2(WPB) : 1;
  localparam int QW  = (NQ > 1) ? $clog2(NQ) : 1;

  localparam logic [AW-1:0] BLK_LAST  = AW'(KB - 1);
  localparam logic [WW-1:0] WORD_LAST = WW'(WPB - 1);
  localparam logic [QW-1:0] Q_LAST    = QW'(NQ - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_MSG  = 2'd2,
    S_PAR  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   block_q, block_d;
  logic [WW-1:0]   word_q, word_d;
  logic [QW-1:0]   q_q, q_d;
  logic            load_q, load_d;
  logic            sys_q, sys_d;
  logic [GW-1:0]   g_q, g_d;
  logic [GW-1:0]   par_q, par_d;
  logic [P-1:0]    m_data_q, m_data_d;
  logic            m_valid_q, m_valid_d;
  logic            m_par_q, m_par_d;
  logic            m_last_q, m_last_d;

  logic            out_free;
  logic            accept;
  logic [GW-1:0]   contrib;

  // Row i of a circulant is row 0 moved i places toward higher bit indices, per B-bit segment.
  function automatic logic [GW-1:0] rot_all(input logic [GW-1:0] x, input int sh);
    logic [GW-1:0] r;
    logic [B-1:0]  seg;
    r = '0;
    for (int n = 0; n < NP; n++) begin
      seg = x[n*B +: B];
      r[n*B +: B] = (seg << sh) | (seg >> (B - sh));
    end
    return r;
  endfunction

  assign out_free = !m_valid_q || m_ready;
  assign accept   = (state_q == S_MSG) && s_valid && out_free;

  always_comb begin
    contrib = '0;
    for (int t = 0; t < P; t++) begin
      if (s_data[t]) begin
        contrib = contrib ^ rot_all(g_q, t);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    block_d   = block_q;
    word_d    = word_q;
    q_d       = q_q;
    load_d    = load_q;
    sys_d     = sys_q;
    g_d       = g_q;
    par_d     = par_q;
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q && !m_ready;
    m_par_d   = m_par_q;
    m_last_d  = m_last_q;

    case (state_q)
      S_IDLE: begin
        if (s_valid) begin
          par_d   = '0;
          block_d = '0;
          sys_d   = sys_en;
          load_d  = 1'b0;
          state_d = S_LOAD;
        end
      end

      // First LOAD cycle presents g_addr; the ROM answers in the second.
      S_LOAD: begin
        if (!load_q) begin
          load_d = 1'b1;
        end else begin
          load_d  = 1'b0;
          g_d     = g_data;
          word_d  = '0;
          state_d = S_MSG;
        end
      end

      S_MSG: begin
        if (accept) begin
          par_d = par_q ^ contrib;
          g_d   = rot_all(g_q, P);
          if (sys_q) begin
            m_data_d  = s_data;
            m_valid_d = 1'b1;
            m_par_d   = 1'b0;
            m_last_d  = 1'b0;
          end
          if (word_q == WORD_LAST) begin
            word_d = '0;
            if (block_q == BLK_LAST) begin
              q_d     = '0;
              state_d = S_PAR;
            end else begin
              block_d = block_q + AW'(1);
              load_d  = 1'b0;
              state_d = S_LOAD;
            end
          end else begin
            word_d = word_q + WW'(1);
          end
        end
      end

      S_PAR: begin
        if (m_valid_q && m_last_q && m_ready) begin
          m_valid_d = 1'b0;
          m_last_d  = 1'b0;
          m_par_d   = 1'b0;
          q_d       = '0;
          block_d   = '0;
          state_d   = S_IDLE;
        end else if (out_free) begin
          m_data_d  = par_q[int'(q_q)*P +: P];
          m_valid_d = 1'b1;
          m_par_d   = 1'b1;
          m_last_d  = (q_q == Q_LAST);
          if (q_q != Q_LAST) begin
            q_d = q_q + QW'(1);
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      block_q   <= '0;
      word_q    <= '0;
      q_q       <= '0;
      load_q    <= 1'b0;
      sys_q     <= 1'b0;
      g_q       <= '0;
      par_q     <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      m_par_q   <= 1'b0;
      m_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      block_q   <= block_d;
      word_q    <= word_d;
      q_q       <= q_d;
      load_q    <= load_d;
      sys_q     <= sys_d;
      g_q       <= g_d;
      par_q     <= par_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      m_par_q   <= m_par_d;
      m_last_q  <= m_last_d;
    end
  end

  assign s_ready = (state_q == S_MSG) && out_free;
  assign g_addr  = block_q;
  assign m_data  = m_data_q;
  assign m_valid = m_valid_q;
  assign m_par   = m_par_q;
  assign m_last  = m_last_q;
  assign busy    = (state_q != S_IDLE);

endmodule
